// File: rtl/num_classifier_pkg.sv
// Shared types and helpers for the number classifier: FSM encodings and
// a constant ceil-log2 used for remainder and bit-counter widths.
package num_classifier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Smallest r with 2**r >= v; used only at elaboration time.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/num_classifier_if.sv
// Valid/ready request and result bus between a producer, the classifier
// and a consumer.
interface num_classifier_if
    import num_classifier_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIVISOR = 3
);
    localparam int unsigned REM_W = clog2(DIVISOR);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_even;
    logic             out_odd;
    logic [REM_W-1:0] out_rem;
    logic             out_div;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_even, out_odd, out_rem, out_div
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_even, out_odd, out_rem, out_div
    );

endinterface

// File: rtl/num_classifier_mod2_step.sv
// One MSB-first remainder step: rem_out = (2*rem_in + bit_in) mod DIVISOR,
// valid because rem_in < DIVISOR keeps the sum below 2*DIVISOR.
module num_classifier_mod2_step
    import num_classifier_pkg::*;
#(
    parameter  int unsigned DIVISOR = 3,
    localparam int unsigned REM_W   = clog2(DIVISOR)
) (
    input  logic [REM_W-1:0] i_rem,
    input  logic             i_bit,
    output logic [REM_W-1:0] o_rem
);

    logic [REM_W:0] w_t;

    assign w_t = {i_rem, i_bit};

    always_comb begin
        o_rem = w_t[REM_W-1:0];
        if (w_t >= (REM_W+1)'(DIVISOR)) begin
            o_rem = REM_W'(w_t - (REM_W+1)'(DIVISOR));
        end
    end

endmodule

// File: rtl/num_classifier.sv
// Handshaked number classifier: even/odd flags, bit-serial remainder modulo
// DIVISOR, and saturating counts of even and odd results handed off.
module num_classifier
    import num_classifier_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIVISOR = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    num_classifier_if.slave  bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] even_cnt,
    output logic [CNT_W-1:0] odd_cnt
);

    localparam int unsigned REM_W = clog2(DIVISOR);
    localparam int unsigned BIT_W = clog2(WIDTH + 1);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_even;
    logic               r_out_odd;
    logic               r_out_div;
    logic [REM_W-1:0]   r_rem;
    logic [WIDTH-1:0]   r_shift;
    logic [BIT_W-1:0]   r_bitcnt;
    logic [CNT_W-1:0]   r_even_cnt;
    logic [CNT_W-1:0]   r_odd_cnt;
    logic [REM_W-1:0]   w_rem_next;
    logic               w_hs_out;

    num_classifier_mod2_step #(
        .DIVISOR (DIVISOR)
    ) u_step (
        .i_rem (r_rem),
        .i_bit (r_shift[WIDTH-1]),
        .o_rem (w_rem_next)
    );

    assign w_hs_out = r_out_valid && bus.out_ready;

    // FSM, datapath and output registers; the remainder register doubles as out_rem.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_even  <= 1'b0;
            r_out_odd   <= 1'b0;
            r_out_div   <= 1'b0;
            r_rem       <= '0;
            r_shift     <= '0;
            r_bitcnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (bus.in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_shift    <= bus.in_data;
                        r_out_data <= bus.in_data;
                        r_rem      <= '0;
                        r_bitcnt   <= '0;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_rem    <= w_rem_next;
                    r_shift  <= r_shift << 1;
                    r_bitcnt <= r_bitcnt + BIT_W'(1);
                    if (r_bitcnt == BIT_W'(WIDTH - 1)) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out_even  <= ~r_out_data[0];
                        r_out_odd   <= r_out_data[0];
                        r_out_div   <= (w_rem_next == '0);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating statistics; a clear on the handshake edge drops that result.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            r_even_cnt <= '0;
            r_odd_cnt  <= '0;
        end else if (w_hs_out) begin
            if (r_out_even && (r_even_cnt != {CNT_W{1'b1}})) begin
                r_even_cnt <= r_even_cnt + CNT_W'(1);
            end
            if (r_out_odd && (r_odd_cnt != {CNT_W{1'b1}})) begin
                r_odd_cnt <= r_odd_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_even  = r_out_even;
    assign bus.out_odd   = r_out_odd;
    assign bus.out_rem   = r_rem;
    assign bus.out_div   = r_out_div;
    assign even_cnt      = r_even_cnt;
    assign odd_cnt       = r_odd_cnt;

endmodule

// File: tb/tb_num_classifier.sv
// Directed bench: three classifiers (mod 3, mod 3 with 2-bit counters, mod 2)
// share one stimulus stream and are checked against bench-side models.
module tb_num_classifier;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       clr;

    logic [15:0] m_even_cnt, m_odd_cnt, d_even_cnt, d_odd_cnt;
    logic [1:0]  s_even_cnt, s_odd_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // bench models of the counters
    int exp_me = 0, exp_mo = 0, exp_se = 0, exp_so = 0;

    always #5 clk = ~clk;

    num_classifier_if #(.WIDTH(8), .DIVISOR(3)) bus_m ();
    num_classifier_if #(.WIDTH(8), .DIVISOR(3)) bus_s ();
    num_classifier_if #(.WIDTH(8), .DIVISOR(2)) bus_d ();

    assign bus_m.in_valid = in_valid;  assign bus_m.in_data = in_data;  assign bus_m.out_ready = out_ready;
    assign bus_s.in_valid = in_valid;  assign bus_s.in_data = in_data;  assign bus_s.out_ready = out_ready;
    assign bus_d.in_valid = in_valid;  assign bus_d.in_data = in_data;  assign bus_d.out_ready = out_ready;

    num_classifier #(.WIDTH(8), .DIVISOR(3), .CNT_W(16)) u_main (
        .clk(clk), .rst_n(rst_n), .bus(bus_m), .clr_cnt(clr),
        .even_cnt(m_even_cnt), .odd_cnt(m_odd_cnt)
    );
    num_classifier #(.WIDTH(8), .DIVISOR(3), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_s), .clr_cnt(clr),
        .even_cnt(s_even_cnt), .odd_cnt(s_odd_cnt)
    );
    num_classifier #(.WIDTH(8), .DIVISOR(2), .CNT_W(16)) u_d2 (
        .clk(clk), .rst_n(rst_n), .bus(bus_d), .clr_cnt(clr),
        .even_cnt(d_even_cnt), .odd_cnt(d_odd_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_m_even"}, 32'(m_even_cnt), exp_me);
        chk({tag, "_m_odd"},  32'(m_odd_cnt),  exp_mo);
        chk({tag, "_s_even"}, 32'(s_even_cnt), exp_se);
        chk({tag, "_s_odd"},  32'(s_odd_cnt),  exp_so);
    endtask

    // One transaction, entered and left at a falling edge. hold = cycles with
    // out_ready low after out_valid; clr_hs = pulse clr_cnt on the handshake edge.
    task automatic send(input logic [7:0] v, input int hold, input bit clr_hs);
        int   n;
        bit   busy_ok;
        logic e, o;
        logic [1:0] r3;
        e  = ~v[0];
        o  = v[0];
        r3 = 2'(v % 3);
        in_valid  = 1'b1;
        in_data   = v;
        out_ready = (hold == 0);
        n = 0;
        while (!bus_m.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(bus_m.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_data = ~v;  // still valid, must be ignored while busy
        busy_ok = 1'b1;
        n = 0;
        while (!bus_m.out_valid && n < 50) begin
            if (bus_m.in_ready) busy_ok = 1'b0;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("latency",       32'(n), 32'd8);
        chk("busy_no_ready", 32'(busy_ok), 32'd1);
        chk("done_no_ready", 32'(bus_m.in_ready), 32'd0);
        chk("out_data",      32'(bus_m.out_data), 32'(v));
        chk("out_even",      32'(bus_m.out_even), 32'(e));
        chk("out_odd",       32'(bus_m.out_odd),  32'(o));
        chk("out_rem",       32'(bus_m.out_rem),  32'(r3));
        chk("out_div",       32'(bus_m.out_div),  32'(r3 == 2'd0));
        chk("d2_rem",        32'(bus_d.out_rem),  32'(o));
        chk("d2_div",        32'(bus_d.out_div),  32'(e));
        chk("d2_div_is_even", 32'(bus_d.out_div), 32'(bus_d.out_even));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(bus_m.out_valid), 32'd1);
            chk("hold_rem",   32'(bus_m.out_rem),   32'(r3));
            chk("hold_even",  32'(bus_m.out_even),  32'(e));
            chk("hold_ready", 32'(bus_m.in_ready),  32'd0);
            chk_counts("hold");
        end
        out_ready = 1'b1;
        clr = clr_hs;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        if (clr_hs) begin
            exp_me = 0; exp_mo = 0; exp_se = 0; exp_so = 0;
        end else begin
            exp_me += int'(e);
            exp_mo += int'(o);
            if (e && exp_se < 3) exp_se++;
            if (o && exp_so < 3) exp_so++;
        end
        chk("post_valid", 32'(bus_m.out_valid), 32'd0);
        chk("post_ready", 32'(bus_m.in_ready),  32'd1);
        chk_counts("post");
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        clr       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus_m.out_valid), 32'd0);
        chk("rst_ready", 32'(bus_m.in_ready),  32'd0);
        chk("rst_data",  32'(bus_m.out_data),  32'd0);
        chk("rst_even",  32'(bus_m.out_even),  32'd0);
        chk("rst_odd",   32'(bus_m.out_odd),   32'd0);
        chk("rst_rem",   32'(bus_m.out_rem),   32'd0);
        chk("rst_div",   32'(bus_m.out_div),   32'd0);
        chk_counts("rst");
        rst_n = 1'b1;

        // basic, then back-to-back with the consumer always ready
        send(8'd4, 0, 1'b0);
        send(8'd7, 0, 1'b0);
        send(8'd9, 0, 1'b0);
        send(8'd0, 0, 1'b0);
        send(8'd255, 0, 1'b0);

        // consumer stalls for five cycles
        send(8'd10, 5, 1'b0);
        chk("stall_even_cnt", 32'(m_even_cnt), 32'd3);

        // standalone clear, then a counted mix
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        exp_me = 0; exp_mo = 0; exp_se = 0; exp_so = 0;
        chk_counts("clr");
        send(8'd2, 0, 1'b0);
        send(8'd4, 0, 1'b0);
        send(8'd6, 0, 1'b0);
        send(8'd3, 0, 1'b0);
        send(8'd5, 0, 1'b0);
        chk("mix_even_cnt", 32'(m_even_cnt), 32'd3);
        chk("mix_odd_cnt",  32'(m_odd_cnt),  32'd2);
        send(8'd8, 0, 1'b1);
        chk("clr_hs_even", 32'(m_even_cnt), 32'd0);

        // saturation of the 2-bit counters
        send(8'd12, 0, 1'b0);
        send(8'd14, 0, 1'b0);
        send(8'd16, 0, 1'b0);
        send(8'd18, 0, 1'b0);
        send(8'd20, 0, 1'b0);
        chk("sat_even_cnt",  32'(s_even_cnt), 32'd3);
        chk("main_even_cnt", 32'(m_even_cnt), 32'd5);

        // reset three edges after acceptance of 200
        in_valid = 1'b1;
        in_data  = 8'd200;
        begin
            int n;
            n = 0;
            while (!bus_m.in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_me = 0; exp_mo = 0; exp_se = 0; exp_so = 0;
        chk("midrst_ready", 32'(bus_m.in_ready),  32'd0);
        chk("midrst_valid", 32'(bus_m.out_valid), 32'd0);
        rst_n = 1'b1;
        begin
            bit rose;
            rose = 1'b0;
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (bus_m.out_valid) rose = 1'b1;
            end
            chk("midrst_no_valid", 32'(rose), 32'd0);
        end
        chk("midrst_ready_back", 32'(bus_m.in_ready), 32'd1);
        chk_counts("midrst");
        send(8'd10, 0, 1'b0);

        // divisor 2 sweep (checked inside every transaction)
        for (int v = 0; v < 16; v++) begin
            send(8'(v), 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
